// File: rtl/ifetch_unit.sv
// -----------------------------------------------------------------------------
// ifetch_unit
//
// Instruction fetch stage sitting directly behind the PC register. One fetch
// is in flight at a time: request the current PC, wait for the single
// response that follows the grant, hold the word for decode, then request
// again. A one-cycle pc_advance strobe tells the upstream next-PC mux to
// load PC+4 exactly once per instruction delivered to decode.
//
// Handshakes (all sampled on the rising edge of pc_clk):
//   imem_req/imem_gnt       : a request is accepted in any cycle where both
//                             are high; imem_addr is only meaningful then.
//   imem_rvalid/imem_rdata  : exactly one response per grant, at least one
//                             cycle after it; no back-pressure on responses.
//   if_valid/if_ready       : the word in if_instr/if_pc transfers to decode
//                             in a cycle where both are high; while if_valid
//                             is high and no transfer occurs, if_instr and
//                             if_pc stay stable.
//
// Ports:
//   pc_clk        clock, rising edge
//   rst           asynchronous, active-high reset
//   pc_in         current PC from the PC register
//   pc_advance    one-cycle strobe: PC register loads PC+4 at the next edge
//   imem_req      instruction memory request
//   imem_addr     request address (follows pc_in)
//   imem_gnt      memory accepted the request this cycle
//   imem_rvalid   response valid
//   imem_rdata    response data
//   flush         redirect: drop held/in-flight instruction
//   if_valid      if_instr/if_pc valid to decode
//   if_ready      decode accepts
//   if_instr      instruction register
//   if_pc         PC of if_instr
//   misalign_err  sticky: a fetch was attempted at a PC with [1:0] != 0
//   dbg_state     current FSM state, for observation only
// -----------------------------------------------------------------------------
module ifetch_unit #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              pc_clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_advance,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  input  logic              flush,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [DATA_W-1:0] if_instr,
  output logic [ADDR_W-1:0] if_pc,
  output logic              misalign_err,
  output logic [2:0]        dbg_state
);

  // REQ   : requesting pc_in, waiting for a grant
  // WAIT  : granted, waiting for the response
  // HOLD  : instruction presented to decode
  // DRAIN : a granted fetch was flushed; swallow its response
  // HALT  : misaligned PC seen; frozen until reset
  typedef enum logic [2:0] {
    S_REQ   = 3'd0,
    S_WAIT  = 3'd1,
    S_HOLD  = 3'd2,
    S_DRAIN = 3'd3,
    S_HALT  = 3'd4
  } state_t;

  state_t state;
  state_t state_nxt;

  logic              pc_misaligned;
  logic [ADDR_W-1:0] req_pc;

  // Strobes from the output decode into the datapath registers.
  logic ld_req_pc;
  logic ld_instr;
  logic set_misalign;

  assign pc_misaligned = |pc_in[1:0];

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge pc_clk or posedge rst) begin
    if (rst) begin
      state <= S_REQ;
    end else begin
      state <= state_nxt;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    state_nxt = state;
    case (state)
      S_REQ: begin
        if (pc_misaligned) begin
          state_nxt = S_HALT;
        end else if (imem_gnt) begin
          // A flush in the grant cycle still leaves a response owed to us,
          // so it has to be drained rather than simply forgotten.
          state_nxt = flush ? S_DRAIN : S_WAIT;
        end
      end
      S_WAIT: begin
        if (imem_rvalid) begin
          state_nxt = flush ? S_REQ : S_HOLD;
        end else if (flush) begin
          state_nxt = S_DRAIN;
        end
      end
      S_HOLD: begin
        // Responses arriving here are protocol errors and are ignored.
        if (flush || if_ready) begin
          state_nxt = S_REQ;
        end
      end
      S_DRAIN: begin
        if (imem_rvalid) begin
          state_nxt = S_REQ;
        end
      end
      S_HALT: begin
        state_nxt = S_HALT;
      end
      default: begin
        state_nxt = S_REQ;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Output decode
  // ---------------------------------------------------------------------------
  // imem_req and pc_advance are gated by rst so they are low for the whole
  // reset window, not only once the state register has been cleared.
  always_comb begin
    imem_req     = 1'b0;
    pc_advance   = 1'b0;
    if_valid     = 1'b0;
    ld_req_pc    = 1'b0;
    ld_instr     = 1'b0;
    set_misalign = 1'b0;
    case (state)
      S_REQ: begin
        if (pc_misaligned) begin
          set_misalign = 1'b1;
        end else begin
          imem_req  = ~rst;
          ld_req_pc = imem_gnt;
        end
      end
      S_WAIT: begin
        if (imem_rvalid && !flush) begin
          pc_advance = ~rst;
          ld_instr   = 1'b1;
        end
      end
      S_HOLD: begin
        if_valid = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign imem_addr = pc_in;
  assign dbg_state = state;

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // The PC register upstream may move on (flush) while a fetch is in flight,
  // so the granted address is kept here to tag the returned word.
  always_ff @(posedge pc_clk or posedge rst) begin
    if (rst) begin
      req_pc <= '0;
    end else if (ld_req_pc) begin
      req_pc <= pc_in;
    end
  end

  always_ff @(posedge pc_clk or posedge rst) begin
    if (rst) begin
      if_instr <= '0;
      if_pc    <= '0;
    end else if (ld_instr) begin
      if_instr <= imem_rdata;
      if_pc    <= req_pc;
    end
  end

  always_ff @(posedge pc_clk or posedge rst) begin
    if (rst) begin
      misalign_err <= 1'b0;
    end else if (set_misalign) begin
      misalign_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifetch_unit.sv
// -----------------------------------------------------------------------------
// tb_ifetch_unit
//
// Directed scenarios for fetch, back-pressure, flush in each state, spurious
// responses, misaligned PC and asynchronous reset, followed by a randomized
// run against a transaction-level model of the fetch stage: a PC register,
// a one-outstanding-request memory with random latency, and an expected
// queue of {pc, instr} words owed to decode.
// Inputs are driven 1 time unit after the rising edge; outputs are checked
// on the falling edge.
// -----------------------------------------------------------------------------
module tb_ifetch_unit;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int RAND_CYCLES = 3000;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic pc_clk = 1'b0;
  logic rst;
  always #5 pc_clk = ~pc_clk;

  logic [AW-1:0] pc_in;
  logic          pc_advance;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_gnt;
  logic          imem_rvalid;
  logic [DW-1:0] imem_rdata;
  logic          flush;
  logic          if_valid;
  logic          if_ready;
  logic [DW-1:0] if_instr;
  logic [AW-1:0] if_pc;
  logic          misalign_err;
  logic [2:0]    dbg_state;

  ifetch_unit #(.ADDR_W(AW), .DATA_W(DW)) dut (
    .pc_clk      (pc_clk),
    .rst         (rst),
    .pc_in       (pc_in),
    .pc_advance  (pc_advance),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .flush       (flush),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_instr    (if_instr),
    .if_pc       (if_pc),
    .misalign_err(misalign_err),
    .dbg_state   (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;
  logic [63:0] exp_q[$];

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Informational only: how often the FSM moved.
  logic [2:0] last_dbg = 3'd0;
  int         n_transitions = 0;
  always @(negedge pc_clk) begin
    if (dbg_state !== last_dbg) n_transitions++;
    last_dbg = dbg_state;
  end

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  task automatic next_cycle();
    @(posedge pc_clk);
    #1;
  endtask

  task automatic sample();
    @(negedge pc_clk);
  endtask

  // ---------------------------------------------------------------------------
  // Randomized run against the transaction model
  // ---------------------------------------------------------------------------
  task automatic random_run();
    bit            mem_busy = 1'b0;
    int            mem_cnt = 0;
    logic [AW-1:0] mem_addr = '0;
    logic [DW-1:0] mem_data = '0;
    bit            poisoned = 1'b0;
    logic [AW-1:0] pc_model = 32'h0000_1000;
    logic [AW-1:0] flush_tgt;
    bit            held;
    bit            exp_req;
    bit            exp_adv;

    exp_q.delete();
    for (int cyc = 0; cyc < RAND_CYCLES; cyc++) begin
      next_cycle();
      pc_in     = pc_model;
      flush     = ($urandom_range(0, 9) == 0);
      flush_tgt = $urandom & 32'hFFFF_FFFC;
      if_ready  = $urandom_range(0, 1);
      imem_gnt  = ($urandom_range(0, 3) != 0);
      if (mem_busy && mem_cnt == 0) begin
        imem_rvalid = 1'b1;
        imem_rdata  = mem_data;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
      end
      sample();

      // Expectations for this cycle.
      held    = (exp_q.size() != 0);
      exp_req = !mem_busy && !held;
      exp_adv = imem_rvalid && mem_busy && !flush && !poisoned;

      check_eq("rnd_req", imem_req, exp_req);
      check_eq("rnd_adv", pc_advance, exp_adv);
      check_eq("rnd_valid", if_valid, held);
      if (exp_req) check_eq("rnd_addr", imem_addr, pc_model);
      if (held) check_eq("rnd_word", {if_pc, if_instr}, exp_q[0]);

      // Model of what the coming edge does.
      if (held && (flush || if_ready)) void'(exp_q.pop_front());
      if (exp_req && imem_gnt) begin
        mem_busy = 1'b1;
        mem_cnt  = $urandom_range(0, 2);
        mem_addr = pc_model;
        mem_data = $urandom;
        poisoned = flush;
      end else if (mem_busy) begin
        if (imem_rvalid) begin
          mem_busy = 1'b0;
          if (exp_adv) exp_q.push_back({mem_addr, mem_data});
        end else begin
          mem_cnt--;
          if (flush) poisoned = 1'b1;
        end
      end
      if (flush) pc_model = flush_tgt;
      else if (exp_adv) pc_model = pc_model + 32'd4;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    rst = 1'b1;
    pc_in = '0;
    imem_gnt = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = '0;
    flush = 1'b0;
    if_ready = 1'b0;

    // Reset values.
    repeat (2) @(posedge pc_clk);
    sample();
    check_eq("rst_req", imem_req, 1'b0);
    check_eq("rst_adv", pc_advance, 1'b0);
    check_eq("rst_valid", if_valid, 1'b0);
    check_eq("rst_instr", if_instr, 32'h0);
    check_eq("rst_pc", if_pc, 32'h0);
    check_eq("rst_misalign", misalign_err, 1'b0);

    // Basic fetch: grant in cycle 0, response in cycle 1, valid from cycle 2.
    next_cycle(); rst = 1'b0; pc_in = 32'h0; imem_gnt = 1'b1;
    sample();
    check_eq("basic_req", imem_req, 1'b1);
    check_eq("basic_addr", imem_addr, 32'h0);
    check_eq("basic_adv0", pc_advance, 1'b0);
    next_cycle(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h2008_0005;
    sample();
    check_eq("basic_adv1", pc_advance, 1'b1);
    check_eq("basic_req1", imem_req, 1'b0);
    check_eq("basic_valid1", if_valid, 1'b0);
    next_cycle(); imem_rvalid = 1'b0; imem_rdata = 32'hFFFF_FFFF; pc_in = 32'h4;
    sample();
    check_eq("basic_valid", if_valid, 1'b1);
    check_eq("basic_instr", if_instr, 32'h2008_0005);
    check_eq("basic_pc", if_pc, 32'h0);
    check_eq("basic_adv2", pc_advance, 1'b0);

    // Back-pressure: 5 cycles of if_ready=0 in total.
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      sample();
      check_eq("bp_valid", if_valid, 1'b1);
      check_eq("bp_instr", if_instr, 32'h2008_0005);
      check_eq("bp_req", imem_req, 1'b0);
      check_eq("bp_adv", pc_advance, 1'b0);
    end
    next_cycle(); if_ready = 1'b1;
    sample();
    check_eq("bp_hs_valid", if_valid, 1'b1);
    check_eq("bp_hs_req", imem_req, 1'b0);
    next_cycle(); if_ready = 1'b0; imem_gnt = 1'b1;
    sample();
    check_eq("bp_next_req", imem_req, 1'b1);
    check_eq("bp_next_addr", imem_addr, 32'h4);
    check_eq("bp_next_valid", if_valid, 1'b0);

    // Flush in WAIT, one cycle before the response.
    next_cycle(); imem_gnt = 1'b0; flush = 1'b1; pc_in = 32'h100;
    sample();
    check_eq("fw_adv0", pc_advance, 1'b0);
    check_eq("fw_req0", imem_req, 1'b0);
    next_cycle(); flush = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    sample();
    check_eq("fw_adv1", pc_advance, 1'b0);
    check_eq("fw_req1", imem_req, 1'b0);
    check_eq("fw_valid1", if_valid, 1'b0);
    next_cycle(); imem_rvalid = 1'b0; imem_gnt = 1'b1;
    sample();
    check_eq("fw_req2", imem_req, 1'b1);
    check_eq("fw_addr2", imem_addr, 32'h100);
    check_eq("fw_valid2", if_valid, 1'b0);

    // Flush coincident with the response.
    next_cycle(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h1111_1111;
    flush = 1'b1; pc_in = 32'h200;
    sample();
    check_eq("fc_adv", pc_advance, 1'b0);
    check_eq("fc_req0", imem_req, 1'b0);
    next_cycle(); imem_rvalid = 1'b0; flush = 1'b0;
    sample();
    check_eq("fc_req1", imem_req, 1'b1);
    check_eq("fc_addr1", imem_addr, 32'h200);
    check_eq("fc_valid1", if_valid, 1'b0);

    // Spurious response in REQ is ignored.
    next_cycle(); imem_rvalid = 1'b1; imem_rdata = 32'h2222_2222;
    sample();
    check_eq("sp_req_adv", pc_advance, 1'b0);
    check_eq("sp_req_req", imem_req, 1'b1);
    next_cycle(); imem_rvalid = 1'b0; imem_gnt = 1'b1;
    sample();
    check_eq("sp_req_req2", imem_req, 1'b1);
    check_eq("sp_req_valid2", if_valid, 1'b0);

    // Fetch at 0x200, then a spurious response while held.
    next_cycle(); imem_gnt = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'hCAFE_0013;
    sample();
    check_eq("sp_hold_adv", pc_advance, 1'b1);
    next_cycle(); imem_rvalid = 1'b0; pc_in = 32'h204;
    sample();
    check_eq("sp_hold_instr0", if_instr, 32'hCAFE_0013);
    check_eq("sp_hold_pc0", if_pc, 32'h200);
    next_cycle(); imem_rvalid = 1'b1; imem_rdata = 32'h0BAD_F00D;
    sample();
    check_eq("sp_hold_adv1", pc_advance, 1'b0);
    check_eq("sp_hold_valid1", if_valid, 1'b1);
    next_cycle(); imem_rvalid = 1'b0;
    sample();
    check_eq("sp_hold_instr2", if_instr, 32'hCAFE_0013);
    check_eq("sp_hold_valid2", if_valid, 1'b1);

    // Flush while held.
    next_cycle(); flush = 1'b1; pc_in = 32'h300;
    sample();
    check_eq("fh_valid0", if_valid, 1'b1);
    next_cycle(); flush = 1'b0; imem_gnt = 1'b1;
    sample();
    check_eq("fh_valid1", if_valid, 1'b0);
    check_eq("fh_req1", imem_req, 1'b1);
    check_eq("fh_addr1", imem_addr, 32'h300);

    // Asynchronous reset in WAIT, asserted mid-cycle.
    next_cycle(); imem_gnt = 1'b0;
    sample();
    check_eq("ar_wait_req", imem_req, 1'b0);
    #2 rst = 1'b1;
    #1;
    check_eq("ar_instr", if_instr, 32'h0);
    check_eq("ar_pc", if_pc, 32'h0);
    check_eq("ar_valid", if_valid, 1'b0);
    check_eq("ar_req", imem_req, 1'b0);
    check_eq("ar_adv", pc_advance, 1'b0);
    next_cycle(); rst = 1'b0; pc_in = 32'h300;
    sample();
    check_eq("ar_restart_req", imem_req, 1'b1);
    check_eq("ar_restart_addr", imem_addr, 32'h300);
    check_eq("ar_restart_valid", if_valid, 1'b0);

    // Misaligned PC: halts until reset.
    next_cycle(); pc_in = 32'h6;
    sample();
    check_eq("mis_req0", imem_req, 1'b0);
    check_eq("mis_err0", misalign_err, 1'b0);
    next_cycle(); pc_in = 32'h8;
    sample();
    check_eq("mis_err1", misalign_err, 1'b1);
    check_eq("mis_req1", imem_req, 1'b0);
    next_cycle(); imem_gnt = 1'b1;
    sample();
    check_eq("mis_req2", imem_req, 1'b0);
    check_eq("mis_err2", misalign_err, 1'b1);
    check_eq("mis_valid2", if_valid, 1'b0);
    next_cycle(); imem_gnt = 1'b0; rst = 1'b1;
    sample();
    check_eq("mis_err_rst", misalign_err, 1'b0);
    check_eq("mis_req_rst", imem_req, 1'b0);
    next_cycle(); rst = 1'b0; pc_in = 32'h0000_1000;
    sample();
    check_eq("mis_after_req", imem_req, 1'b1);
    check_eq("mis_after_addr", imem_addr, 32'h0000_1000);

    // Randomized traffic from a clean REQ state.
    next_cycle(); rst = 1'b1;
    next_cycle(); rst = 1'b0;
    random_run();

    $display("info: state changes seen %0d", n_transitions);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/ifetch_unit.md
# ifetch_unit

Instruction fetch stage directly downstream of the PC register. Each cycle it reads the current PC, issues a request to instruction memory over a grant/response handshake, and holds the returned word in an instruction register. That register is presented to decode with a valid/ready handshake. It drives a one-cycle `pc_advance` strobe so the next-PC mux upstream loads the following PC, and it supports flush/redirect with correct discard of in-flight responses.

## Interface
- `ADDR_W`, 32, PC and instruction-memory address width
- `DATA_W`, 32, instruction width
- `pc_clk`  in  1  clock, all state updates on rising edge
- `rst`  in  1  reset, asynchronous, active-high
- `pc_in`  in  ADDR_W  current PC from PC register
- `pc_advance`  out  1  one-cycle strobe: next-PC mux selects PC+4 and the PC register loads it at the following edge
- `imem_req`  out  1  instruction memory request
- `imem_addr`  out  ADDR_W  request address; equals `pc_in` while `imem_req`=1
- `imem_gnt`  in  1  memory accepted the request this cycle
- `imem_rvalid`  in  1  response valid; exactly one response per grant, at least 1 cycle after the grant
- `imem_rdata`  in  DATA_W  response data, valid when `imem_rvalid`=1
- `flush`  in  1  redirect: discard held/in-flight instruction; upstream writes the target into the PC register the same cycle
- `if_valid`  out  1  `if_instr`/`if_pc` valid to decode
- `if_ready`  in  1  decode accepts when `if_valid`&`if_ready`
- `if_instr`  out  DATA_W  instruction register
- `if_pc`  out  ADDR_W  PC of `if_instr`
- `misalign_err`  out  1  sticky: fetch attempted at PC with [1:0]≠0

## Operation
- FSM states: REQ, WAIT, HOLD, DRAIN, HALT. Reset state: REQ.
- **REQ**
  - `imem_req`=1, `imem_addr`=`pc_in`.
  - If `pc_in[1:0]`≠0: `imem_req`=0, set `misalign_err`, go to HALT.
  - On `imem_gnt`: latch `pc_in` into the request-PC register, then go to WAIT, or to DRAIN if `flush`=1 the same cycle.
- **WAIT**
  - `imem_req`=0.
  - On `imem_rvalid`&!`flush`: load `if_instr`←`imem_rdata`, `if_pc`←request PC, set `if_valid`, assert `pc_advance` (combinational, this cycle only), go to HOLD.
  - `flush`&`imem_rvalid`: discard the response, no `pc_advance`, go to REQ.
  - `flush`&!`imem_rvalid`: go to DRAIN.
- **HOLD**
  - `if_valid`=1; `if_instr`/`if_pc` held stable.
  - On `if_ready`: clear `if_valid`, go to REQ.
  - On `flush` (priority over `if_ready`): clear `if_valid`, go to REQ.
- **DRAIN**
  - `imem_req`=0. On `imem_rvalid`: discard, go to REQ. `flush` has no extra effect.
- **HALT**
  - All request and handshake outputs 0. Exits only on `rst`.
- `pc_advance` is asserted only in WAIT on an accepted response, so exactly one PC increment per instruction delivered.

## Timing
- Reset values: `if_valid`=0, `if_instr`=0, `if_pc`=0, `misalign_err`=0, state=REQ.
- During `rst`=1, `imem_req`=0 and `pc_advance`=0.
- Minimum latency, PC to `if_valid`: grant in cycle 0, `rvalid` in cycle 1, `if_valid` high from cycle 2.
- Peak throughput: one instruction per 3 cycles (grant, response, handoff). No overlapping requests.
- `rst` mid-transaction: the FSM returns to REQ asynchronously. Any response arriving after reset release while in REQ is ignored; the memory is also reset by the same `rst`.
- `imem_rvalid` in REQ or HOLD is a protocol error and is ignored (no state change).
- Back-pressure: while `if_ready`=0, no new request is issued and the PC does not advance.

## Test plan
- **Basic fetch:** reset release, `pc_in`=0x0000_0000, `imem_gnt`=1 in the first cycle, `rvalid` the next with `rdata`=0x2008_0005 -> `pc_advance` pulses 1 cycle; `if_valid`=1 with `if_instr`=0x2008_0005, `if_pc`=0.
- **Back-pressure:** `if_ready`=0 for 5 cycles in HOLD -> `if_valid` held, `if_instr` stable, `imem_req`=0, no `pc_advance`. Raising `if_ready` -> `imem_req` the next cycle at the new `pc_in`=0x4.
- **Flush in WAIT:** `flush` 1 cycle before `rvalid` -> response discarded, no `pc_advance`, `if_valid` stays 0. The next request uses the redirected `pc_in`=0x0000_0100.
- **Flush coincident with `rvalid`:** response discarded, no `pc_advance`, `imem_req`=1 the next cycle.
- **Misaligned PC:** `pc_in`=0x0000_0006 in REQ -> `misalign_err`=1, `imem_req`=0 and stays 0; after `rst` pulse `misalign_err`=0.
- **Async reset:** `rst` asserted in WAIT mid-cycle -> outputs go to reset values before the next edge. Fetch restarts at `pc_in` after release.
